// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM for a multicycle RISC-style datapath.
//                Sequences fetch/decode/execute/memory/writeback, drives
//                datapath strobes and selects, traps on unknown opcodes
//                and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        reg_write,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [1:0]  aluOp,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_EXEC_I   = 4'd10,
        S_I_WB     = 4'd11,
        S_JAL      = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [6:0]  r_opcode;
    logic        r_illegal;
    logic [31:0] r_retired;
    logic        w_retire;

    // State register plus the opcode latch, sticky trap flag and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_opcode  <= 7'd0;
            r_illegal <= 1'b0;
            r_retired <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
            end
            if (w_next_state == S_TRAP) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    // Next-state and output decode; only FETCH strobes and the memory waits see mem_ready
    always_comb begin
        w_next_state  = r_state;
        w_retire      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        aluOp         = 2'b00;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    C_OP_LOAD, C_OP_STORE: w_next_state = S_MEM_ADDR;
                    C_OP_RTYPE:            w_next_state = S_EXEC_R;
                    C_OP_BRANCH:           w_next_state = S_BRANCH;
                    C_OP_ITYPE:            w_next_state = S_EXEC_I;
                    C_OP_JAL:              w_next_state = S_JAL;
                    default:               w_next_state = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                // The latched copy decides, so a changing IR cannot redirect the access
                w_next_state = (r_opcode == C_OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 2'b01;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_FETCH;
                    w_retire     = 1'b1;
                end
            end
            S_EXEC_R: begin
                alu_src_a    = 2'b01;
                aluOp        = 2'b10;
                w_next_state = S_R_WB;
            end
            S_R_WB: begin
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 2'b01;
                aluOp         = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                w_next_state  = S_FETCH;
                w_retire      = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                w_next_state = S_I_WB;
            end
            S_I_WB: begin
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_JAL: begin
                pc_write     = 1'b1;
                pc_source    = 2'b01;
                reg_write    = 1'b1;
                mem_to_reg   = 2'b10;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_TRAP: begin
                w_next_state = S_TRAP;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Scoreboard bench for multicycle_control. Stimulus pushes the
//                hand-derived expected outputs per cycle; a monitor pops and
//                compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_write;
    logic [1:0]  mem_to_reg, alu_src_a, alu_src_b, pc_source, aluOp;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] retired;

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .aluOp         (aluOp),
        .state         (state),
        .illegal       (illegal),
        .retired       (retired)
    );

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  strb;   // pc_write,pc_write_cond,ir_write,mem_read,mem_write,i_or_d,reg_write
        logic [9:0]  sel;    // mem_to_reg,alu_src_a,alu_src_b,pc_source,aluOp
        logic        ill;
        logic [31:0] ret;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected strobes per state, read off the state table
    function automatic logic [6:0] exp_strb(input logic [3:0] st, input logic rdy);
        case (st)
            4'd1:    return {rdy, 1'b0, rdy, 1'b1, 3'b000};
            4'd4:    return 7'b0001010;
            4'd5:    return 7'b0000001;
            4'd6:    return 7'b0000110;
            4'd8:    return 7'b0000001;
            4'd9:    return 7'b0100000;
            4'd11:   return 7'b0000001;
            4'd12:   return 7'b1000001;
            default: return 7'b0000000;
        endcase
    endfunction

    // Expected selects per state, read off the state table
    function automatic logic [9:0] exp_sel(input logic [3:0] st);
        case (st)
            4'd1:    return 10'b00_00_01_00_00;
            4'd2:    return 10'b00_00_11_00_00;
            4'd3:    return 10'b00_01_10_00_00;
            4'd5:    return 10'b01_00_00_00_00;
            4'd7:    return 10'b00_01_00_00_10;
            4'd9:    return 10'b00_01_00_01_01;
            4'd10:   return 10'b00_01_10_00_00;
            4'd12:   return 10'b10_00_00_01_00;
            default: return 10'b00_00_00_00_00;
        endcase
    endfunction

    // One cycle of stimulus: drive inputs, record what this cycle must show
    task automatic step(input logic r, input logic rdy, input logic [6:0] op,
                        input logic [3:0] st, input logic ill, input logic [31:0] ret,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = rdy;
        opcode    = op;
        e.st   = st;
        e.strb = exp_strb(st, rdy);
        e.sel  = exp_sel(st);
        e.ill  = ill;
        e.ret  = ret;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare every presented cycle against the scoreboard head
    initial begin
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a.st   = state;
                a.strb = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_write};
                a.sel  = {mem_to_reg, alu_src_a, alu_src_b, pc_source, aluOp};
                a.ill  = illegal;
                a.ret  = retired;
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s: got st=%0d strb=%b sel=%b ill=%b ret=%0d, want st=%0d strb=%b sel=%b ill=%b ret=%0d",
                             nm, a.st, a.strb, a.sel, a.ill, a.ret, e.st, e.strb, e.sel, e.ill, e.ret);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        opcode    = 7'd0;

        // Reset and first release edge
        step(1, 0, 7'd0, 0, 0, 0, "reset_idle");
        step(0, 1, 7'd0, 0, 0, 0, "idle_release");

        // R-type: 1,2,7,8,1
        step(0, 1, 7'd0, 1, 0, 0, "r_fetch");
        step(0, 1, OP_R, 2, 0, 0, "r_decode");
        step(0, 1, OP_R, 7, 0, 0, "r_exec");
        step(0, 1, OP_R, 8, 0, 0, "r_wb");

        // Load with three wait cycles; opcode changes after DECODE
        step(0, 1, 7'd0,  1, 0, 1, "ld_fetch");
        step(0, 1, OP_LD, 2, 0, 1, "ld_decode");
        step(0, 1, OP_ST, 3, 0, 1, "ld_addr");
        for (int i = 0; i < 3; i++) step(0, 0, OP_ST, 4, 0, 1, "ld_wait");
        step(0, 1, OP_ST, 4, 0, 1, "ld_ready");
        step(0, 0, OP_ST, 5, 0, 1, "ld_wb");

        // Fetch stall of five cycles, then illegal opcode
        for (int i = 0; i < 5; i++) step(0, 0, 7'd0, 1, 0, 2, "fetch_stall");
        step(0, 1, 7'd0,   1, 0, 2, "fetch_ready");
        step(0, 1, OP_BAD, 2, 0, 2, "bad_decode");
        for (int i = 0; i < 11; i++) step(0, i[0], OP_R, 15, 1, 2, "trap_hold");
        step(1, 1, OP_R, 15, 1, 2, "trap_rst");
        step(0, 1, OP_R, 0, 0, 0, "trap_cleared");

        // Store with reset during the memory wait
        step(0, 1, 7'd0,  1, 0, 0, "st_fetch");
        step(0, 1, OP_ST, 2, 0, 0, "st_decode");
        step(0, 1, OP_LD, 3, 0, 0, "st_addr");
        step(0, 0, OP_LD, 6, 0, 0, "st_wait");
        step(1, 0, OP_LD, 6, 0, 0, "st_wait_rst");
        step(0, 1, 7'd0,  0, 0, 0, "st_rst_idle");

        // Mixed: branch, JAL, store, ADDI
        step(0, 1, 7'd0,   1, 0, 0, "mx_fetch0");
        step(0, 1, OP_BR,  2, 0, 0, "br_decode");
        step(0, 0, OP_BR,  9, 0, 0, "br_exec");
        step(0, 1, 7'd0,   1, 0, 1, "mx_fetch1");
        step(0, 1, OP_JAL, 2, 0, 1, "jal_decode");
        step(0, 0, OP_JAL, 12, 0, 1, "jal_exec");
        step(0, 1, 7'd0,   1, 0, 2, "mx_fetch2");
        step(0, 1, OP_ST,  2, 0, 2, "st2_decode");
        step(0, 0, OP_ST,  3, 0, 2, "st2_addr");
        step(0, 1, OP_ST,  6, 0, 2, "st2_write");
        step(0, 1, 7'd0,   1, 0, 3, "mx_fetch3");
        step(0, 1, OP_I,   2, 0, 3, "addi_decode");
        step(0, 0, OP_I,   10, 0, 3, "addi_exec");
        step(0, 0, OP_I,   11, 0, 3, "addi_wb");
        step(0, 0, 7'd0,   1, 0, 4, "mx_retired4");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
